rv_timer: RTL

//  Memory-mapped 32-bit timer/compare peripheral on the rv_core data bus, sibling of rv_sio.

---
 rtl/rv_types.sv | 30 +++
 rtl/rv_prescaler.sv | 27 ++
 rtl/rv_timer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/rv_types.sv
// Shared definitions for the rv_timer peripheral: bus window, register offsets, bit indices.
package rv_types;

    localparam logic [31:0] RV_TIMER_BASE = 32'hffff_0040;

    // Register select is adr[4:2]
    localparam logic [2:0] REG_CTRL = 3'd0;
    localparam logic [2:0] REG_PSC  = 3'd1;
    localparam logic [2:0] REG_CMP  = 3'd2;
    localparam logic [2:0] REG_CNT  = 3'd3;
    localparam logic [2:0] REG_STAT = 3'd4;
    localparam logic [2:0] REG_CAP  = 3'd5;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_AR    = 1;
    localparam int CTRL_IE    = 2;
    localparam int STAT_MATCH = 0;
    localparam int STAT_CAPF  = 1;

    function automatic logic [31:0] merge_be(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/rv_prescaler.sv
// Prescaler for rv_timer: counts enabled cycles and emits a one-cycle tick every div+1 cycles.
module rv_prescaler #(
    parameter int PSC_W = 16
) (
    input  logic             clk,
    input  logic             xreset,
    input  logic             en,
    input  logic             clr,
    input  logic [PSC_W-1:0] div,
    output logic             tick
);

    logic [PSC_W-1:0] pcnt;

    assign tick = en & (pcnt == div);

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            pcnt <= '0;
        end else if (clr) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/rv_timer.sv
// Memory-mapped 32-bit timer/compare peripheral with level irq on compare match.
// Optional capture input enabled by defining RV_TIMER_CAPTURE_EN.
module rv_timer
    import rv_types::*;
#(
    parameter int          PSC_W   = 16,
    parameter logic [31:0] RST_CMP = 32'hffff_ffff
) (
    input  logic        clk,
    input  logic        xreset,
    input  logic [4:0]  adr,
    input  logic        cs,
    input  logic        rdy,
    input  logic [3:0]  we,
    input  logic        re,
    input  logic [31:0] dw,
    output logic [31:0] dr,
    output logic        irq,
    input  logic        cap
);

    logic [2:0]       ctrl;
    logic [PSC_W-1:0] psc;
    logic [31:0]      cmp;
    logic [31:0]      cnt;
    logic             match;
    logic             capf;
    logic [31:0]      cap_q;
    logic             tick;
    logic [31:0]      rdata;

    logic       acc;
    logic       wr_any;
    logic [2:0] sel;
    logic       wr_ctrl, wr_psc, wr_cmp, wr_cnt, wr_stat;
    logic       match_set, clr_match;
    logic       adr_unused;

    assign acc     = cs & rdy;
    assign wr_any  = acc & (|we);
    assign sel     = adr[4:2];
    assign wr_ctrl = wr_any & (sel == REG_CTRL);
    assign wr_psc  = wr_any & (sel == REG_PSC);
    assign wr_cmp  = wr_any & (sel == REG_CMP);
    assign wr_cnt  = wr_any & (sel == REG_CNT);
    assign wr_stat = wr_any & (sel == REG_STAT);
    assign adr_unused = ^adr[1:0];

    // A bus write to CNT overrides the tick, so no compare is evaluated that cycle
    assign match_set = tick & ~wr_cnt & (cnt == cmp);
    assign clr_match = wr_stat & we[0] & dw[STAT_MATCH];

    rv_prescaler #(.PSC_W(PSC_W)) u_psc (
        .clk    (clk),
        .xreset (xreset),
        .en     (ctrl[CTRL_EN]),
        .clr    (wr_ctrl | wr_psc),
        .div    (psc),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            ctrl  <= '0;
            psc   <= '0;
            cmp   <= RST_CMP;
            cnt   <= '0;
            match <= 1'b0;
        end else begin
            if (wr_ctrl && we[0])
                ctrl <= dw[2:0];
            if (wr_psc) begin
                for (int i = 0; i < PSC_W; i++)
                    if (we[i/8]) psc[i] <= dw[i];
            end
            if (wr_cmp)
                cmp <= merge_be(cmp, dw, we);
            if (wr_cnt)
                cnt <= merge_be(cnt, dw, we);
            else if (tick)
                cnt <= ((cnt == cmp) && ctrl[CTRL_AR]) ? 32'd0 : cnt + 32'd1;
            // Set has priority over a coincident write-1-to-clear
            if (match_set)
                match <= 1'b1;
            else if (clr_match)
                match <= 1'b0;
        end
    end

`ifdef RV_TIMER_CAPTURE_EN
    logic cap_s1, cap_s2, cap_s3;
    logic cap_rise, clr_capf;

    assign cap_rise = cap_s2 & ~cap_s3;
    assign clr_capf = wr_stat & we[0] & dw[STAT_CAPF];

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            cap_s1 <= 1'b0;
            cap_s2 <= 1'b0;
            cap_s3 <= 1'b0;
            cap_q  <= '0;
            capf   <= 1'b0;
        end else begin
            cap_s1 <= cap;
            cap_s2 <= cap_s1;
            cap_s3 <= cap_s2;
            if (cap_rise)
                cap_q <= cnt;
            if (cap_rise)
                capf <= 1'b1;
            else if (clr_capf)
                capf <= 1'b0;
        end
    end
`else
    logic cap_unused;

    assign cap_unused = cap;
    assign cap_q      = '0;
    assign capf       = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (sel)
            REG_CTRL: rdata = {29'd0, ctrl};
            REG_PSC:  rdata = 32'(psc);
            REG_CMP:  rdata = cmp;
            REG_CNT:  rdata = cnt;
            REG_STAT: rdata = {30'd0, capf, match};
            REG_CAP:  rdata = cap_q;
            default:  rdata = '0;
        endcase
    end

    // Idle cycles return zero so the top level can OR the peripheral read buses
    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset)
            dr <= '0;
        else
            dr <= (acc & re) ? rdata : 32'd0;
    end

    assign irq = (match | capf) & ctrl[CTRL_IE];

endmodule
